// File: rtl/idx_vec_builder.sv
// -----------------------------------------------------------------------------
// idx_vec_builder
//
// Rebuilds a WIDTH-bit vector from a stream of bit indices. This is the inverse
// of a most-significant-set-bit index encoder. Each accepted index sets its bit
// in an accumulator. An index flagged "last" closes the vector, which is then
// presented on a valid/ready handshake.
//
// Parameters
//   WIDTH : vector width (>= 1)
//   IDXW  : index width, $clog2(WIDTH) with a minimum of 1 (derived)
//
// Ports
//   i_clk          clock
//   i_rst          synchronous reset, active-high
//   i_cg           clock-gate enable; 0 holds all state
//   i_index        bit index to set
//   i_indexLast    this index closes the current vector
//   i_indexValid   index offered
//   o_indexReady   index accepted when valid & ready (combinational)
//   o_vector       completed vector
//   o_vectorValid  o_vector valid
//   i_vectorReady  consumer takes o_vector
//   o_dup          sticky per vector: an accepted index was already set
//   o_rangeErr     sticky per vector: an accepted index was >= WIDTH
//   o_mssb         (IDX_VEC_BUILDER_MSSB_EN only) index of the most
//                  significant set bit of o_vector, 0 when o_vector == 0
//
// Build option
//   IDX_VEC_BUILDER_MSSB_EN : adds the o_mssb output
// -----------------------------------------------------------------------------
module idx_vec_builder #(
  parameter  int WIDTH = 7,
  localparam int IDXW  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cg,
  input  logic [IDXW-1:0]  i_index,
  input  logic             i_indexLast,
  input  logic             i_indexValid,
  output logic             o_indexReady,
  output logic [WIDTH-1:0] o_vector,
  output logic             o_vectorValid,
  input  logic             i_vectorReady,
  output logic             o_dup,
  output logic             o_rangeErr
`ifdef IDX_VEC_BUILDER_MSSB_EN
  ,
  output logic [IDXW-1:0]  o_mssb
`endif
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t           r_state, w_nextState;
  logic [WIDTH-1:0] r_acc, w_nextAcc;
  logic [WIDTH-1:0] r_vector, w_nextVector;
  logic             r_vectorValid, w_nextVectorValid;
  logic             r_dup, w_nextDup;
  logic             r_rangeErr, w_nextRangeErr;

  logic             w_indexReady;
  logic             w_accIdx;
  logic             w_inRange;
  logic [WIDTH-1:0] w_bit;
  logic [WIDTH-1:0] w_mergedAcc;
  logic             w_isDup;
  logic             w_vecDone;

`ifdef IDX_VEC_BUILDER_MSSB_EN
  logic [IDXW-1:0]  r_mssb, w_nextMssb;

  // Index of the most significant set bit; 0 for an all-zero vector.
  function automatic logic [IDXW-1:0] mssbIdx(input logic [WIDTH-1:0] v);
    logic [IDXW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (v[i]) r = IDXW'(i);
    end
    return r;
  endfunction
`endif

  // Extra leading zero so the compare also works when WIDTH == 2**IDXW.
  assign w_inRange    = ({1'b0, i_index} < (IDXW+1)'(WIDTH));
  assign w_bit        = w_inRange ? (WIDTH'(1) << i_index) : '0;
  assign w_mergedAcc  = r_acc | w_bit;
  assign w_isDup      = |(r_acc & w_bit);

  assign w_indexReady = i_cg && (r_state == ACCUM);
  assign w_accIdx     = i_indexValid && w_indexReady;
  assign w_vecDone    = r_vectorValid && i_vectorReady && i_cg;

  always_comb begin
    w_nextState       = r_state;
    w_nextAcc         = r_acc;
    w_nextVector      = r_vector;
    w_nextVectorValid = r_vectorValid;
    w_nextDup         = r_dup;
    w_nextRangeErr    = r_rangeErr;
`ifdef IDX_VEC_BUILDER_MSSB_EN
    w_nextMssb        = r_mssb;
`endif
    unique case (r_state)
      ACCUM: begin
        if (w_accIdx) begin
          w_nextAcc = w_mergedAcc;
          if (w_isDup)    w_nextDup      = 1'b1;
          if (!w_inRange) w_nextRangeErr = 1'b1;
          if (i_indexLast) begin
            // The closing index is folded into the presented vector.
            w_nextVector      = w_mergedAcc;
            w_nextVectorValid = 1'b1;
            w_nextState       = HOLD;
`ifdef IDX_VEC_BUILDER_MSSB_EN
            w_nextMssb        = mssbIdx(w_mergedAcc);
`endif
          end
        end
      end
      HOLD: begin
        if (w_vecDone) begin
          // o_vector keeps its last value; only valid and the flags clear.
          w_nextVectorValid = 1'b0;
          w_nextAcc         = '0;
          w_nextDup         = 1'b0;
          w_nextRangeErr    = 1'b0;
          w_nextState       = ACCUM;
        end
      end
      default: w_nextState = ACCUM;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ACCUM;
      r_acc         <= '0;
      r_vector      <= '0;
      r_vectorValid <= 1'b0;
      r_dup         <= 1'b0;
      r_rangeErr    <= 1'b0;
`ifdef IDX_VEC_BUILDER_MSSB_EN
      r_mssb        <= '0;
`endif
    end else if (i_cg) begin
      r_state       <= w_nextState;
      r_acc         <= w_nextAcc;
      r_vector      <= w_nextVector;
      r_vectorValid <= w_nextVectorValid;
      r_dup         <= w_nextDup;
      r_rangeErr    <= w_nextRangeErr;
`ifdef IDX_VEC_BUILDER_MSSB_EN
      r_mssb        <= w_nextMssb;
`endif
    end
  end

  assign o_indexReady  = w_indexReady;
  assign o_vector      = r_vector;
  assign o_vectorValid = r_vectorValid;
  assign o_dup         = r_dup;
  assign o_rangeErr    = r_rangeErr;
`ifdef IDX_VEC_BUILDER_MSSB_EN
  assign o_mssb        = r_mssb;
`endif

endmodule
